// File: rtl/defines_pkg.sv
// Shared encodings for the memory stage: memop codes, byte-enable
// patterns, FSM state type and small decode helpers.
package defines;

    localparam int MEMOP_W = 4;

    localparam logic [MEMOP_W-1:0] MEMOP_NONE = 4'd0;
    localparam logic [MEMOP_W-1:0] MEMOP_LB   = 4'd1;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU  = 4'd2;
    localparam logic [MEMOP_W-1:0] MEMOP_LH   = 4'd3;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU  = 4'd4;
    localparam logic [MEMOP_W-1:0] MEMOP_LW   = 4'd5;
    localparam logic [MEMOP_W-1:0] MEMOP_SB   = 4'd6;
    localparam logic [MEMOP_W-1:0] MEMOP_SH   = 4'd7;
    localparam logic [MEMOP_W-1:0] MEMOP_SW   = 4'd8;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic memop_is_load(input logic [MEMOP_W-1:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LW);
    endfunction

    function automatic logic memop_is_store(input logic [MEMOP_W-1:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SW);
    endfunction

    // Byte ops are always aligned; halves need bit 0 clear, words both bits.
    function automatic logic memop_aligned(input logic [MEMOP_W-1:0] op,
                                           input logic [1:0]         a);
        logic ok;
        ok = 1'b1;
        if (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) ok = ~a[0];
        if (op == MEMOP_LW || op == MEMOP_SW)                    ok = (a == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
    import defines::*;
(
    input  logic [MEMOP_W-1:0] i_memop,
    input  logic [1:0]         i_addr_lo,
    input  logic [31:0]        i_rdata,
    output logic [31:0]        o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extension chosen by load flavour; LW (and anything else) passes the word.
    always_comb begin
        o_data = i_rdata;
        case (i_memop)
            MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            MEMOP_LBU: o_data = {24'b0, w_byte};
            MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
            MEMOP_LHU: o_data = {16'b0, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus,
// stalls upstream while the access is outstanding, aborts after TIMEOUT
// cycles without ack, and feeds aligned load data to MEM/WB.
module mem_stage
    import defines::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MEMOP_W-1:0] ex_memop,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_sdata,
    input  logic               ex_we,
    input  logic [4:0]         ex_waddr,
    input  logic [31:0]        ex_wdata,
    output logic               mem_we,
    output logic [4:0]         mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               stall_req,
    output logic               exc_adel,
    output logic               exc_ades,
    output logic               bus_err,
    output logic               dbus_req,
    output logic               dbus_wr,
    output logic [31:0]        dbus_addr,
    output logic [3:0]         dbus_be,
    output logic [31:0]        dbus_wdata,
    input  logic [31:0]        dbus_rdata,
    input  logic               dbus_ack
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_ldata;
    logic             r_bus_err;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_aligned;
    logic        w_issue;
    logic        w_timeout;
    logic        w_req;
    logic        w_ack;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_align_data;

    assign w_is_load  = memop_is_load(ex_memop);
    assign w_is_store = memop_is_store(ex_memop);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_aligned  = memop_aligned(ex_memop, ex_addr[1:0]);
    assign w_issue    = (r_state == ST_IDLE) & w_is_mem & w_aligned;
    // The cycle the counter hits TIMEOUT is the abort cycle: request dropped.
    assign w_timeout  = (r_state == ST_BUSY) & (r_cnt == TO_VAL);
    assign w_req      = w_issue | ((r_state == ST_BUSY) & ~w_timeout);
    // Ack only counts while a request is actually on the bus.
    assign w_ack      = w_req & dbus_ack;
    assign w_stall    = w_issue | (r_state == ST_BUSY);

    load_align u_load_align (
        .i_memop   (ex_memop),
        .i_addr_lo (ex_addr[1:0]),
        .i_rdata   (dbus_rdata),
        .o_data    (w_align_data)
    );

    // Lane steering for sub-word stores; loads and SW use all four lanes.
    always_comb begin
        w_be    = BE_WORD;
        w_wdata = ex_sdata;
        case (ex_memop)
            MEMOP_SB: begin
                w_be    = BE_BYTE << ex_addr[1:0];
                w_wdata = {4{ex_sdata[7:0]}};
            end
            MEMOP_SH: begin
                w_be    = BE_HALF << ex_addr[1:0];
                w_wdata = {2{ex_sdata[15:0]}};
            end
            default: begin
                w_be    = BE_WORD;
                w_wdata = ex_sdata;
            end
        endcase
    end

    // Next-state logic for the IDLE -> BUSY -> DONE access sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_next = dbus_ack ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (w_timeout)     w_next = ST_IDLE;
                else if (dbus_ack) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Wait counter: runs only in BUSY, cleared everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_cnt <= '0;
        else if (r_state == ST_BUSY && !w_timeout) r_cnt <= r_cnt + 1'b1;
        else                                       r_cnt <= '0;
    end

    // Load buffer captures the aligned word on the accepted ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ldata <= '0;
        else if (w_ack) r_ldata <= w_align_data;
    end

    // Timeout pulse is registered, so it shows the cycle after the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bus_err <= 1'b0;
        else        r_bus_err <= w_timeout;
    end

    // Output drive; everything is forced low while reset is asserted.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        stall_req  = 1'b0;
        exc_adel   = 1'b0;
        exc_ades   = 1'b0;
        bus_err    = 1'b0;
        dbus_req   = 1'b0;
        dbus_wr    = 1'b0;
        dbus_addr  = '0;
        dbus_be    = '0;
        dbus_wdata = '0;
        if (rst_n) begin
            stall_req = w_stall;
            bus_err   = r_bus_err;
            exc_adel  = (r_state == ST_IDLE) & w_is_load  & ~w_aligned;
            exc_ades  = (r_state == ST_IDLE) & w_is_store & ~w_aligned;
            dbus_req  = w_req;
            if (w_req) begin
                dbus_wr    = w_is_store;
                dbus_addr  = {ex_addr[31:2], 2'b00};
                dbus_be    = w_be;
                dbus_wdata = w_wdata;
            end
            mem_waddr = ex_waddr;
            mem_wdata = (r_state == ST_DONE && w_is_load) ? r_ldata : ex_wdata;
            // Bubble while stalled or when the access faulted.
            mem_we    = ex_we & ~w_stall & ~exc_adel & ~exc_ades;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-backs into a
// scoreboard queue, a monitor pops them whenever mem_we is seen.
module tb_mem_stage;
    import defines::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [MEMOP_W-1:0] ex_memop;
    logic [31:0]        ex_addr, ex_sdata, ex_wdata;
    logic               ex_we;
    logic [4:0]         ex_waddr;
    logic               mem_we;
    logic [4:0]         mem_waddr;
    logic [31:0]        mem_wdata;
    logic               stall_req, exc_adel, exc_ades, bus_err;
    logic               dbus_req, dbus_wr;
    logic [31:0]        dbus_addr, dbus_wdata;
    logic [3:0]         dbus_be;
    logic [31:0]        dbus_rdata;
    logic               dbus_ack;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_delay = -1;
    int rcnt = 0;
    logic [36:0] sb[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_err(bus_err), .dbus_req(dbus_req), .dbus_wr(dbus_wr),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Bus slave: acks ack_delay cycles after the request first appears.
    always @(negedge clk) begin
        if (dbus_req) begin
            dbus_ack = (ack_delay >= 0) && (rcnt == ack_delay);
            rcnt++;
        end else begin
            dbus_ack = 1'b0;
            rcnt = 0;
        end
    end

    // Monitor: every write-back must match the oldest expected entry.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wb: got waddr %0d wdata %h, expected no write",
                         mem_waddr, mem_wdata);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("wb_waddr", {27'b0, mem_waddr}, {27'b0, e[36:32]});
                chk("wb_wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic bubble();
        ex_memop = MEMOP_NONE; ex_addr = '0; ex_sdata = '0;
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        ack_delay = -1;
    endtask

    // Issue one instruction, hold it until stall_req drops, then bubble.
    task automatic run(input string nm, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input int dly, input int exp_stall,
                       input logic push, input logic [31:0] exp_wd,
                       output logic [3:0] be0, output logic [31:0] a0, output logic [31:0] w0,
                       output logic req0, output logic wr0, output logic adel0, output logic ades0);
        int  stalls;
        bit  done;
        @(posedge clk); #1;
        if (push) sb.push_back({wa, exp_wd});
        ex_memop = op; ex_addr = addr; ex_sdata = sdata;
        ex_we = we; ex_waddr = wa; ex_wdata = wd;
        dbus_rdata = rdata; ack_delay = dly;
        stalls = 0; done = 0;
        be0 = '0; a0 = '0; w0 = '0; req0 = 0; wr0 = 0; adel0 = 0; ades0 = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                be0 = dbus_be; a0 = dbus_addr; w0 = dbus_wdata;
                req0 = dbus_req; wr0 = dbus_wr; adel0 = exc_adel; ades0 = exc_ades;
            end
            if (!stall_req) done = 1;
            else stalls++;
        end
        chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk); #1;
        bubble();
    endtask

    logic [3:0]  be0;
    logic [31:0] a0, w0;
    logic        req0, wr0, adel0, ades0;
    logic [8:0]  reqv, errv, stv;

    initial begin
        rst_n = 1'b0;
        dbus_rdata = '0;
        dbus_ack = 1'b0;
        bubble();
        ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h1111;
        #3;
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_req", {31'b0, dbus_req}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        bubble();
        @(negedge clk); rst_n = 1'b1;

        // Pass-through ALU op
        run("add", MEMOP_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, -1, 0, 1'b1, 32'h1234,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("add_req", {31'b0, req0}, 32'd0);
        // Unused encoding behaves as NONE
        run("op9", 4'd9, 32'h0, 32'h0, 32'h0, 1'b1, 5'd13, 32'h55, -1, 0, 1'b1, 32'h55,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("op9_req", {31'b0, req0}, 32'd0);

        // Loads with various alignment/extension and ack latency
        run("lb", MEMOP_LB, 32'h1003, 32'h0, 32'h80FF_FF11, 1'b1, 5'd7, 32'hDEAD, 0, 1, 1'b1, 32'hFFFF_FF80,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("lb_addr", a0, 32'h1000);
        chk("lb_be", {28'b0, be0}, 32'hF);
        chk("lb_wr", {31'b0, wr0}, 32'd0);
        run("lbu", MEMOP_LBU, 32'h1001, 32'h0, 32'h80FF_FF11, 1'b1, 5'd8, 32'h0, 1, 2, 1'b1, 32'h0000_00FF,
            be0, a0, w0, req0, wr0, adel0, ades0);
        run("lh", MEMOP_LH, 32'h1002, 32'h0, 32'h80FF_FF11, 1'b1, 5'd9, 32'h0, 0, 1, 1'b1, 32'hFFFF_80FF,
            be0, a0, w0, req0, wr0, adel0, ades0);
        run("lhu", MEMOP_LHU, 32'h1000, 32'h0, 32'h80FF_FF11, 1'b1, 5'd10, 32'h0, 2, 3, 1'b1, 32'h0000_FF11,
            be0, a0, w0, req0, wr0, adel0, ades0);
        run("lw", MEMOP_LW, 32'h1004, 32'h0, 32'h1234_5678, 1'b1, 5'd11, 32'h0, 0, 1, 1'b1, 32'h1234_5678,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("lw_addr", a0, 32'h1004);

        // Stores
        run("sh", MEMOP_SH, 32'h2002, 32'hAAAA_BEEF, 32'h0, 1'b0, 5'd0, 32'h2002, 3, 4, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("sh_be", {28'b0, be0}, 32'hC);
        chk("sh_wdata", w0, 32'hBEEF_BEEF);
        chk("sh_addr", a0, 32'h2000);
        chk("sh_wr", {31'b0, wr0}, 32'd1);
        run("sb", MEMOP_SB, 32'h3001, 32'h1234_565A, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("sb_be", {28'b0, be0}, 32'h2);
        chk("sb_wdata", w0, 32'h5A5A_5A5A);
        chk("sb_addr", a0, 32'h3000);
        run("sw", MEMOP_SW, 32'h3008, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("sw_be", {28'b0, be0}, 32'hF);
        chk("sw_wdata", w0, 32'hCAFE_F00D);

        // Misaligned accesses: flagged, no bus access, no stall, no write-back
        run("lw_mis", MEMOP_LW, 32'h0002, 32'h0, 32'h0, 1'b1, 5'd12, 32'h77, 0, 0, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("lw_mis_adel", {31'b0, adel0}, 32'd1);
        chk("lw_mis_req", {31'b0, req0}, 32'd0);
        run("lh_mis", MEMOP_LH, 32'h0003, 32'h0, 32'h0, 1'b1, 5'd12, 32'h77, 0, 0, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("lh_mis_adel", {31'b0, adel0}, 32'd1);
        run("sw_mis", MEMOP_SW, 32'h0001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 0, 1'b0, 32'h0,
            be0, a0, w0, req0, wr0, adel0, ades0);
        chk("sw_mis_ades", {31'b0, ades0}, 32'd1);
        chk("sw_mis_adel", {31'b0, adel0}, 32'd0);

        // Timeout (TIMEOUT=4): 4 held BUSY cycles, abort cycle with req low,
        // bus_err the cycle after, request reissued immediately.
        @(posedge clk); #1;
        ex_memop = MEMOP_LW; ex_addr = 32'h4000; ex_we = 1'b1; ex_waddr = 5'd14;
        ack_delay = -1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            reqv[c] = dbus_req; errv[c] = bus_err; stv[c] = stall_req;
        end
        chk("to_req_seq", {23'b0, reqv}, 32'b1_1101_1111);
        chk("to_err_seq", {23'b0, errv}, 32'b0_0100_0000);
        chk("to_stall_seq", {23'b0, stv}, 32'h1FF);

        // Reset while BUSY: outputs drop at once, FSM back in IDLE afterwards
        rst_n = 1'b0;
        #1;
        chk("rstb_req", {31'b0, dbus_req}, 32'd0);
        chk("rstb_stall", {31'b0, stall_req}, 32'd0);
        chk("rstb_mem_we", {31'b0, mem_we}, 32'd0);
        bubble();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, stall_req}, 32'd0);
        chk("post_rst_req", {31'b0, dbus_req}, 32'd0);
        chk("post_rst_err", {31'b0, bus_err}, 32'd0);
        run("lw_after_rst", MEMOP_LW, 32'h5000, 32'h0, 32'hA5A5_0F0F, 1'b1, 5'd15, 32'h0, 0, 1, 1'b1, 32'hA5A5_0F0F,
            be0, a0, w0, req0, wr0, adel0, ades0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
